// File: rtl/timer16_pkg.sv
// timer16 shared definitions: register offsets, bit indices, CTRL layout.
package timer16_pkg;

  // Register offsets, taken from addr[3:1].
  localparam logic [2:0] CtrlOffset     = 3'd0;
  localparam logic [2:0] StatusOffset   = 3'd1;
  localparam logic [2:0] CountOffset    = 3'd2;
  localparam logic [2:0] ReloadOffset   = 3'd3;
  localparam logic [2:0] PrescaleOffset = 3'd4;

  // CTRL bit positions.
  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlAutoBit = 1;
  localparam int unsigned CtrlIeBit   = 2;

  // STATUS bit positions.
  localparam int unsigned StatusOvfBit = 0;
  localparam int unsigned StatusRunBit = 1;

  // CTRL register layout; field order matches the bit indices above.
  typedef struct packed {
    logic ie;
    logic auto_reload;
    logic en;
  } ctrl_t;

  // Apply per-byte enables to a 16-bit register value.
  function automatic logic [15:0] byte_merge(input logic [15:0] old_val,
                                             input logic [15:0] new_val,
                                             input logic [1:0]  be);
    logic [15:0] result;
    result = old_val;
    if (be[0]) result[7:0]  = new_val[7:0];
    if (be[1]) result[15:8] = new_val[15:8];
    return result;
  endfunction

endpackage

// File: rtl/timer16_if.sv
// CPU data-bus port into the timer16 register block.
interface timer16_if;
  logic [15:0] dread_addr;
  logic [15:0] dread_data;
  logic [15:0] dwrite_addr;
  logic [15:0] dwrite_data;
  logic [1:0]  dwrite_en;
  logic        interrupt;

  modport master (
    output dread_addr, dwrite_addr, dwrite_data, dwrite_en,
    input  dread_data, interrupt
  );

  modport slave (
    input  dread_addr, dwrite_addr, dwrite_data, dwrite_en,
    output dread_data, interrupt
  );
endinterface

// File: rtl/timer16_prescaler.sv
// 8-bit prescaler: tick fires every div+1 clocks while enabled.
module timer16_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       restart,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] pc_q, pc_d;

  assign tick = en & (pc_q == div);

  // Next prescale count: held at zero when disabled or restarted, wraps on tick.
  always_comb begin
    pc_d = pc_q;
    if (!en || restart) begin
      pc_d = '0;
    end else if (tick) begin
      pc_d = '0;
    end else begin
      pc_d = pc_q + 8'd1;
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/timer16.sv
// 16-bit down-counting timer with prescaler, auto-reload and W1C overflow status.
module timer16
  import timer16_pkg::*;
#(
  parameter logic [15:0] BASEADDR = 16'h0010
) (
  input  logic      clk,
  input  logic      reset,
  timer16_if.slave  bus
);

  ctrl_t       ctrl_q, ctrl_d;
  logic        ovf_q, ovf_d;
  logic [15:0] count_q, count_d;
  logic [15:0] reload_q, reload_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [15:0] dread_data_q, rd_val;

  logic        wr_hit, rd_hit;
  logic [2:0]  wr_off, rd_off;
  logic        wr_ctrl, wr_status, wr_count, wr_reload, wr_prescale;
  logic [1:0]  be;
  logic [15:0] wdata;
  logic        tick, ovf_set, ovf_clr, en_rise, restart;

  // addr[0] is don't-care: registers are halfword-addressed.
  logic unused_addr_lsb;
  assign unused_addr_lsb = bus.dwrite_addr[0] ^ bus.dread_addr[0];

  assign be     = bus.dwrite_en;
  assign wdata  = bus.dwrite_data;
  assign wr_hit = (bus.dwrite_addr[15:4] == BASEADDR[15:4]) && (be != 2'b00);
  assign wr_off = bus.dwrite_addr[3:1];
  assign rd_hit = (bus.dread_addr[15:4] == BASEADDR[15:4]);
  assign rd_off = bus.dread_addr[3:1];

  assign wr_ctrl     = wr_hit && (wr_off == CtrlOffset);
  assign wr_status   = wr_hit && (wr_off == StatusOffset);
  assign wr_count    = wr_hit && (wr_off == CountOffset);
  assign wr_reload   = wr_hit && (wr_off == ReloadOffset);
  assign wr_prescale = wr_hit && (wr_off == PrescaleOffset);

  // Underflow set takes priority over a same-cycle W1C clear.
  assign ovf_set = tick && (count_q == 16'd0);
  assign ovf_clr = wr_status && be[0] && wdata[StatusOvfBit];

  // Prescaler restarts on any PRESCALE write or when the timer is switched on.
  assign en_rise = ctrl_d.en & ~ctrl_q.en;
  assign restart = wr_prescale | en_rise;

  timer16_prescaler u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (ctrl_q.en),
    .restart (restart),
    .div     (prescale_q),
    .tick    (tick)
  );

  // Next register state: counter action first, CPU writes override it.
  always_comb begin
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    reload_d   = reload_q;
    prescale_d = prescale_q;
    ovf_d      = ovf_set | (ovf_q & ~ovf_clr);

    if (tick) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else if (ctrl_q.auto_reload) begin
        count_d = reload_q;
      end else begin
        ctrl_d.en = 1'b0;
      end
    end

    if (wr_ctrl && be[0]) ctrl_d = ctrl_t'(wdata[2:0]);
    // Merging against count_q drops any same-cycle decrement or reload.
    if (wr_count) count_d = byte_merge(count_q, wdata, be);
    if (wr_reload) reload_d = byte_merge(reload_q, wdata, be);
    if (wr_prescale && be[0]) prescale_d = wdata[7:0];
  end

  // Register file state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      reload_q   <= '0;
      prescale_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      prescale_q <= prescale_d;
    end
  end

  // Read mux over pre-edge register values; unused offsets read zero.
  always_comb begin
    rd_val = '0;
    case (rd_off)
      CtrlOffset: rd_val[2:0] = ctrl_q;
      StatusOffset: begin
        rd_val[StatusOvfBit] = ovf_q;
        rd_val[StatusRunBit] = ctrl_q.en;
      end
      CountOffset:    rd_val = count_q;
      ReloadOffset:   rd_val = reload_q;
      PrescaleOffset: rd_val[7:0] = prescale_q;
      default:        rd_val = '0;
    endcase
  end

  // Registered read data, zero outside the window so the system can OR it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dread_data_q <= '0;
    end else begin
      dread_data_q <= rd_hit ? rd_val : 16'h0000;
    end
  end

  assign bus.dread_data = dread_data_q;
  assign bus.interrupt  = ovf_q & ctrl_q.ie;

endmodule

// File: tb/tb_timer16.sv
// Self-checking bench for timer16: register table plus timing/collision sequences.
module tb_timer16;

  localparam logic [15:0] ACtrl     = 16'h0010;
  localparam logic [15:0] AStatus   = 16'h0012;
  localparam logic [15:0] ACount    = 16'h0014;
  localparam logic [15:0] AReload   = 16'h0016;
  localparam logic [15:0] APrescale = 16'h0018;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  timer16_if bus ();

  timer16 #(.BASEADDR(16'h0010)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
    bus.dwrite_addr = a;
    bus.dwrite_data = d;
    bus.dwrite_en   = b;
    @(posedge clk);
    #1;
    bus.dwrite_en = 2'b00;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    bus.dread_addr = a;
    @(posedge clk);
    #1;
    d = bus.dread_data;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;

    reset           = 1'b0;
    bus.dread_addr  = '0;
    bus.dwrite_addr = '0;
    bus.dwrite_data = '0;
    bus.dwrite_en   = 2'b00;
    idle(2);
    check("reset_dread_data", bus.dread_data, 16'h0000);
    check("reset_interrupt", {15'b0, bus.interrupt}, 16'h0000);
    reset = 1'b1;
    idle(1);

    // Register table with the timer disabled.
    vecs.push_back('{1'b0, ACtrl,     16'h0000, 2'b00, 16'h0000});
    vecs.push_back('{1'b0, AStatus,   16'h0000, 2'b00, 16'h0000});
    vecs.push_back('{1'b0, ACount,    16'h0000, 2'b00, 16'h0000});
    vecs.push_back('{1'b0, AReload,   16'h0000, 2'b00, 16'h0000});
    vecs.push_back('{1'b0, APrescale, 16'h0000, 2'b00, 16'h0000});
    vecs.push_back('{1'b1, AReload,   16'h1234, 2'b11, 16'h0000});
    vecs.push_back('{1'b0, AReload,   16'h0000, 2'b00, 16'h1234});
    vecs.push_back('{1'b1, AReload,   16'hABCD, 2'b10, 16'h0000});
    vecs.push_back('{1'b0, AReload,   16'h0000, 2'b00, 16'hAB34});
    vecs.push_back('{1'b1, AReload,   16'h5678, 2'b01, 16'h0000});
    vecs.push_back('{1'b0, AReload,   16'h0000, 2'b00, 16'hAB78});
    vecs.push_back('{1'b1, APrescale, 16'hFFFF, 2'b11, 16'h0000});
    vecs.push_back('{1'b0, APrescale, 16'h0000, 2'b00, 16'h00FF});
    vecs.push_back('{1'b1, APrescale, 16'h1234, 2'b10, 16'h0000});
    vecs.push_back('{1'b0, APrescale, 16'h0000, 2'b00, 16'h00FF});
    vecs.push_back('{1'b1, ACtrl,     16'hFFFA, 2'b11, 16'h0000});
    vecs.push_back('{1'b0, ACtrl,     16'h0000, 2'b00, 16'h0002});
    vecs.push_back('{1'b1, 16'h0020,  16'hFFFF, 2'b11, 16'h0000});
    vecs.push_back('{1'b0, 16'h0020,  16'h0000, 2'b00, 16'h0000});
    vecs.push_back('{1'b1, 16'h001A,  16'hFFFF, 2'b11, 16'h0000});
    vecs.push_back('{1'b0, 16'h001A,  16'h0000, 2'b00, 16'h0000});
    vecs.push_back('{1'b1, 16'h000F,  16'hFFFF, 2'b11, 16'h0000});
    vecs.push_back('{1'b0, 16'h000F,  16'h0000, 2'b00, 16'h0000});
    vecs.push_back('{1'b0, ACtrl,     16'h0000, 2'b00, 16'h0002});
    vecs.push_back('{1'b0, ACount,    16'h0000, 2'b00, 16'h0000});
    vecs.push_back('{1'b0, AReload,   16'h0000, 2'b00, 16'hAB78});
    vecs.push_back('{1'b0, APrescale, 16'h0000, 2'b00, 16'h00FF});
    vecs.push_back('{1'b1, 16'h0015,  16'h0042, 2'b11, 16'h0000});
    vecs.push_back('{1'b0, ACount,    16'h0000, 2'b00, 16'h0042});
    vecs.push_back('{1'b0, 16'h0015,  16'h0000, 2'b00, 16'h0042});
    vecs.push_back('{1'b1, AStatus,   16'hFFFF, 2'b11, 16'h0000});
    vecs.push_back('{1'b0, AStatus,   16'h0000, 2'b00, 16'h0000});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        wr(vecs[i].addr, vecs[i].data, vecs[i].be);
      end else begin
        rd(vecs[i].addr, d);
        check($sformatf("vec%0d_addr%h", i, vecs[i].addr), d, vecs[i].exp);
      end
    end

    // Read and write of the same register in one cycle returns the old value.
    bus.dread_addr = AReload;
    wr(AReload, 16'h0F0F, 2'b11);
    check("raw_old_value", bus.dread_data, 16'hAB78);
    rd(AReload, d);
    check("raw_new_value", d, 16'h0F0F);

    // One-shot: interrupt exactly 4 clocks after the enabling edge.
    wr(APrescale, 16'h0000, 2'b11);
    wr(ACount, 16'h0003, 2'b11);
    wr(ACtrl, 16'h0005, 2'b11);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      check($sformatf("oneshot_irq_clk%0d", k), {15'b0, bus.interrupt}, (k == 4) ? 16'h1 : 16'h0);
    end
    rd(ACtrl, d);
    check("oneshot_ctrl_en_cleared", d, 16'h0004);
    rd(AStatus, d);
    check("oneshot_status", d, 16'h0001);
    rd(ACount, d);
    check("oneshot_count", d, 16'h0000);
    wr(AStatus, 16'h0001, 2'b01);
    check("oneshot_clear_irq", {15'b0, bus.interrupt}, 16'h0000);

    // Auto-reload, PRESCALE=2, RELOAD=1: overflow every 6 clocks.
    wr(APrescale, 16'h0002, 2'b11);
    wr(AReload, 16'h0001, 2'b11);
    wr(ACount, 16'h0001, 2'b11);
    wr(ACtrl, 16'h0007, 2'b11);
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      check($sformatf("auto_irq_clk%0d", k), {15'b0, bus.interrupt}, (k == 6) ? 16'h1 : 16'h0);
    end
    wr(AStatus, 16'h0001, 2'b11);
    check("auto_clear_irq", {15'b0, bus.interrupt}, 16'h0000);
    for (int k = 8; k <= 12; k++) begin
      idle(1);
      check($sformatf("auto_irq_clk%0d", k), {15'b0, bus.interrupt}, (k == 12) ? 16'h1 : 16'h0);
    end
    wr(AStatus, 16'h0001, 2'b11);
    check("auto_clear2_irq", {15'b0, bus.interrupt}, 16'h0000);
    idle(4);
    // This clear lands on the underflow edge; the set must win.
    wr(AStatus, 16'h0001, 2'b11);
    check("set_beats_clear_irq", {15'b0, bus.interrupt}, 16'h0001);
    rd(AStatus, d);
    check("set_beats_clear_status", d, 16'h0003);

    // COUNT write on a tick cycle wins over the decrement.
    wr(ACtrl, 16'h0000, 2'b11);
    wr(AStatus, 16'h0001, 2'b11);
    wr(APrescale, 16'h0003, 2'b11);
    wr(ACount, 16'h0010, 2'b11);
    wr(ACtrl, 16'h0001, 2'b11);
    idle(3);
    wr(ACount, 16'h0100, 2'b11);
    rd(ACount, d);
    check("write_beats_tick", d, 16'h0100);
    idle(3);
    rd(ACount, d);
    check("next_tick_decrements", d, 16'h00FF);

    // Reset mid-operation with the interrupt active.
    wr(ACtrl, 16'h0000, 2'b11);
    wr(APrescale, 16'h0000, 2'b11);
    wr(AReload, 16'h0000, 2'b11);
    wr(ACount, 16'h0000, 2'b11);
    wr(ACtrl, 16'h0007, 2'b11);
    bus.dread_addr = ACtrl;
    idle(2);
    check("pre_reset_irq", {15'b0, bus.interrupt}, 16'h0001);
    check("pre_reset_dread", bus.dread_data, 16'h0007);
    reset = 1'b0;
    #1;
    check("async_reset_irq", {15'b0, bus.interrupt}, 16'h0000);
    check("async_reset_dread", bus.dread_data, 16'h0000);
    idle(2);
    reset = 1'b1;
    idle(1);
    for (int i = 0; i < 5; i++) begin
      rd(16'h0010 + 16'(2 * i), d);
      check($sformatf("post_reset_off%0d", i), d, 16'h0000);
    end
    check("post_reset_irq", {15'b0, bus.interrupt}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
